// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory bus controller: valid/ready request, response wait with
// timeout, misalignment drop, and pipeline stall generation.
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] BE_WD,
  input  logic [3:0]  ByteEnable,
  output logic [31:0] RD,
  output logic        Stall,
  output logic        MisalignFault,
  output logic        BusError,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic              req, misaligned;
  logic              start, accept, timeout, rsp_take;
  logic [CNT_W-1:0]  cnt;
  logic              req_we;
  logic [29:0]       req_word;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic [31:0]       rd_q;
  logic              bus_err_q;

  assign req = MemRead | MemWrite;

  always_comb begin
    misaligned = ((funct3[1:0] == 2'b01) && Addr[0]) ||
                 ((funct3 == 3'b010) && (Addr[1:0] != 2'b00));
  end

  always_comb begin
    state_nxt     = state;
    Stall         = 1'b0;
    MisalignFault = 1'b0;
    bus_valid     = 1'b0;
    start         = 1'b0;
    accept        = 1'b0;
    timeout       = 1'b0;
    rsp_take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            MisalignFault = 1'b1;
          end else begin
            Stall     = 1'b1;
            start     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        Stall     = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) begin
          accept = 1'b1;
          // A response coinciding with the accept skips the wait state.
          if (bus_rvalid) begin
            rsp_take  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        Stall = 1'b1;
        if (bus_rvalid) begin
          rsp_take  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_we    <= 1'b0;
      req_word  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      rd_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_err_q <= timeout;
      if (start) begin
        req_we    <= MemWrite;
        req_word  <= Addr[31:2];
        req_wdata <= BE_WD;
        req_be    <= MemWrite ? ByteEnable : 4'hF;
      end
      if (accept) begin
        cnt <= '0;
      end else if (state == WAIT_RSP) begin
        cnt <= cnt + 1'b1;
      end
      if (rsp_take && !req_we) begin
        rd_q <= bus_rdata;
      end else if (timeout) begin
        rd_q <= '0;
      end
    end
  end

  assign RD        = rd_q;
  assign BusError  = bus_err_q;
  assign bus_we    = bus_valid & req_we;
  assign bus_addr  = {req_word, 2'b00};
  assign bus_wdata = req_wdata;
  assign bus_be    = req_be;

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-memory access controller in the MEM stage, between the pipeline's load/store path and the data-memory bus.
- Takes the lane-positioned store word and byte enables produced by the byte-enable logic.
- Runs a valid/ready request plus response handshake on the bus, stalling the pipeline for the whole access.
- Returns the raw 32-bit read word to the byte-enable logic for extraction and extension.
- Also detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT_RSP before the access is aborted with BusError.
- CNT_W, 7: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- MemRead  input  1  load in MEM stage
- MemWrite  input  1  store in MEM stage
- Addr  input  32  byte address
- funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- BE_WD  input  32  lane-positioned store data
- ByteEnable  input  4  store lane enables
- RD  output  32  raw read word (registered)
- Stall  output  1  hold IF..MEM stages this cycle
- MisalignFault  output  1  one-cycle pulse: misaligned access dropped
- BusError  output  1  one-cycle pulse: timeout abort
- bus_valid  output  1  request valid
- bus_ready  input  1  request accepted
- bus_we  output  1  write request
- bus_addr  output  32  {Addr[31:2],2'b00}
- bus_wdata  output  32  BE_WD
- bus_be  output  4  ByteEnable for writes, 4'b1111 for reads
- bus_rvalid  input  1  response (read data or write ack)
- bus_rdata  input  32  read data

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, RD=0, counter=0. Outputs Stall, MisalignFault, BusError, bus_valid, bus_we all 0. bus_addr, bus_wdata and bus_be are 0.
- Reset mid-access aborts immediately. Any later bus_rvalid is ignored while in IDLE.
- req = MemRead|MemWrite. If both are set, treat the access as a write.
- Misalignment:
  - Halfword (funct3 x01) with Addr[0]=1.
  - Word (010) with Addr[1:0]≠00.
  - Detected in IDLE. No bus access is made. MisalignFault pulses in that same cycle, combinationally. Stall=0 and RD is unchanged.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - On an aligned req, register the request fields and go to REQ.
  - Stall=1 combinationally in this cycle.
- REQ:
  - bus_valid=1; fields stay stable until bus_ready.
  - On bus_valid&bus_ready go to WAIT_RSP and clear the counter.
  - If bus_rvalid arrives in the same cycle as bus_ready, go straight to DONE and capture data.
  - Stall=1.
- WAIT_RSP:
  - bus_valid=0; counter increments each cycle.
  - On bus_rvalid: RD<=bus_rdata for reads (RD unchanged for writes), then go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without bus_rvalid: RD<=0, BusError pulses for one cycle, go to DONE.
  - Stall=1.
- DONE:
  - Stall=0 for exactly one cycle. RD is valid and the pipeline advances at the end of this cycle.
  - Always go to IDLE next, ignoring current inputs, because they still belong to the finished instruction.
- The pipeline holds Addr, funct3, BE_WD, ByteEnable and MemRead/MemWrite stable while Stall=1. The block uses its registered copies from REQ onward.
- Minimum latency, with bus_ready and bus_rvalid both immediate: 3 cycles (IDLE → REQ → DONE), of which 2 are stalled.
- A bus_rvalid outside WAIT_RSP, or outside REQ-with-accept, is ignored.
- Back-to-back accesses: the second request is seen in the IDLE cycle after DONE. There is no bubble beyond that.

Test Plan:
- Aligned load: lw at Addr=0x100, bus_ready=1 immediately, bus_rvalid 2 cycles after accept with rdata=0xCAFEF00D → bus_addr=0x100, bus_be=1111, Stall high for 4 cycles, RD=0xCAFEF00D in DONE.
- Byte store: sb at Addr=0x203, BE_WD=0xAB000000, ByteEnable=1000, bus_ready held low 3 cycles → bus_valid held 4 cycles with stable fields, bus_addr=0x200, bus_we=1, RD unchanged.
- Misaligned: lw at Addr=0x102 and lh at 0x101 → MisalignFault pulses, bus_valid never asserted, Stall=0.
- Timeout: lw, bus_ready=1, bus_rvalid never → BusError pulses after TIMEOUT_CYCLES cycles in WAIT_RSP, RD=0, then DONE then IDLE.
- Back-to-back plus reset: sw then lw consecutively → two distinct bus transactions with no extra bubble. Then reset_n low during WAIT_RSP, followed by a late bus_rvalid → outputs return to 0, the late response is ignored, and the next access behaves normally.
